// File: rtl/wb_obi_bridge.sv
// -----------------------------------------------------------------------------
// wb_obi_bridge
//
// Wishbone-classic responder that turns every WB access into exactly one OBI
// initiator transaction. Only one transaction is in flight at a time. A
// response timeout makes sure the WB master always gets its ack, even if the
// OBI side never grants or never responds.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous, active-low reset
//   wb_addr_i      WB byte address
//   wb_rdata_o     WB read data (meaningful while wb_ack_o=1)
//   wb_wdata_i     WB write data
//   wb_wr_en_i     1=write, 0=read
//   wb_byte_en_i   WB byte lane enables
//   wb_stb_i       WB strobe
//   wb_ack_o       WB single-cycle acknowledge
//   wb_cyc_i       WB bus cycle
//   obi_req_o      OBI request
//   obi_gnt_i      OBI grant
//   obi_addr_o     OBI address (wb_addr_i + ADDR_OFFSET)
//   obi_we_o       OBI write enable
//   obi_be_o       OBI byte enables
//   obi_wdata_o    OBI write data
//   obi_rvalid_i   OBI response valid
//   obi_rdata_i    OBI read data
//   busy_o         1 whenever the bridge is not idle
//   timeout_o      one-cycle pulse, coincident with the ACK cycle of a
//                  transaction that was force-completed
//
// Handshakes
//   WB side : a request is taken when wb_cyc_i && wb_stb_i in IDLE. wb_ack_o
//             is high for one cycle (the ACK state) and only if wb_cyc_i is
//             still high; a master that dropped wb_cyc_i gets no ack.
//   OBI side: the address phase is complete on a cycle with obi_req_o &&
//             obi_gnt_i; the response phase is complete on the first
//             obi_rvalid_i seen in RESP (after any orphan discard). All
//             address-phase outputs come from registers and are stable while
//             obi_req_o=1. obi_rvalid_i is ignored outside RESP.
//
// Timeout
//   r_cnt holds the number of REQ/RESP cycles already spent before the current
//   one. The TIMEOUT_CYCLES-th REQ/RESP cycle is the last one allowed: if the
//   transaction does not complete in it, the bridge jumps to ACK with
//   TIMEOUT_DATA. If a grant had been given (including a grant that arrives in
//   that very last cycle) a response is still owed by the fabric, so the
//   orphan flag is set and that late response is discarded later.
//   TIMEOUT_CYCLES must be >= 2.
// -----------------------------------------------------------------------------
module wb_obi_bridge #(
  parameter int unsigned                SOC_ADDR_WIDTH = 32,
  parameter logic [SOC_ADDR_WIDTH-1:0]  ADDR_OFFSET    = '0,
  parameter int unsigned                TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [SOC_ADDR_WIDTH-1:0] wb_addr_i,
  output logic [31:0]               wb_rdata_o,
  input  logic [31:0]               wb_wdata_i,
  input  logic                      wb_wr_en_i,
  input  logic [3:0]                wb_byte_en_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  input  logic                      wb_cyc_i,
  output logic                      obi_req_o,
  input  logic                      obi_gnt_i,
  output logic [SOC_ADDR_WIDTH-1:0] obi_addr_o,
  output logic                      obi_we_o,
  output logic [3:0]                obi_be_o,
  output logic [31:0]               obi_wdata_o,
  input  logic                      obi_rvalid_i,
  input  logic [31:0]               obi_rdata_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_orphan;
  logic [SOC_ADDR_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic [3:0]                r_be;
  logic [31:0]               r_wdata;
  logic [31:0]               r_rdata;
  logic                      r_timeout;

  logic w_accept;
  logic w_complete;
  logic w_timeout;
  logic w_set_orphan;
  logic w_clr_orphan;
  logic w_expired;
  logic w_active;

  assign w_active  = (r_state == S_REQ) || (r_state == S_RESP);
  assign w_expired = w_active && (r_cnt == CNT_LAST);

  // Next-state and control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    w_set_orphan = 1'b0;
    w_clr_orphan = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_expired) begin
          // Out of time: withdraw the request. A grant in this same cycle
          // means the fabric accepted it and will answer later.
          w_timeout    = 1'b1;
          w_set_orphan = obi_gnt_i;
          w_state_nxt  = S_ACK;
        end else if (obi_gnt_i) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (obi_rvalid_i && !r_orphan) begin
          w_complete  = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          // A response while the orphan flag is set belongs to an earlier,
          // timed-out transaction: swallow it and keep waiting.
          w_clr_orphan = obi_rvalid_i;
          if (w_expired) begin
            w_timeout    = 1'b1;
            w_set_orphan = 1'b1;
            w_state_nxt  = S_ACK;
          end
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_orphan  <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_be      <= 4'b0;
      r_wdata   <= 32'b0;
      r_rdata   <= 32'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_timeout;

      if (w_accept) begin
        r_addr  <= wb_addr_i + ADDR_OFFSET;
        r_we    <= wb_wr_en_i;
        r_be    <= wb_byte_en_i;
        r_wdata <= wb_wdata_i;
        r_cnt   <= '0;
      end else if (w_active && !w_expired) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Set wins over clear: a discard and a new timeout in the same cycle
      // leave exactly one response outstanding.
      if (w_set_orphan) begin
        r_orphan <= 1'b1;
      end else if (w_clr_orphan) begin
        r_orphan <= 1'b0;
      end

      if (w_complete) begin
        r_rdata <= r_we ? 32'b0 : obi_rdata_i;
      end else if (w_timeout) begin
        r_rdata <= TIMEOUT_DATA;
      end
    end
  end

  assign obi_req_o   = (r_state == S_REQ);
  assign obi_addr_o  = r_addr;
  assign obi_we_o    = r_we;
  assign obi_be_o    = r_be;
  assign obi_wdata_o = r_wdata;
  assign wb_ack_o    = (r_state == S_ACK) && wb_cyc_i;
  assign wb_rdata_o  = r_rdata;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_wb_obi_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for wb_obi_bridge (TIMEOUT_CYCLES=8). A second instance with a
// wrapping ADDR_OFFSET shares all inputs and is checked for address mapping.
// Each transaction is described by: grant delay g (REQ cycles before gnt),
// response delay r (RESP cycles before rvalid), an optional late orphan
// response at RESP offset lo, an optional abort cycle and REQ-phase rvalid
// noise. Expected timing follows directly from these numbers.
// -----------------------------------------------------------------------------
module tb_wb_obi_bridge;

  localparam int unsigned T        = 8;
  localparam logic [31:0] TO_DATA  = 32'hDEAD_BEEF;
  localparam logic [31:0] OFF2     = 32'hF000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] wb_addr, wb_wdata, obi_rdata;
  logic        wb_we, wb_stb, wb_cyc, obi_gnt, obi_rvalid;
  logic [3:0]  wb_be;

  logic [31:0] wb_rdata, obi_addr, obi_wdata;
  logic        wb_ack, obi_req, obi_we, busy, tmo;
  logic [3:0]  obi_be;

  logic [31:0] o2_rdata, o2_addr, o2_wdata;
  logic        o2_ack, o2_req, o2_we, o2_busy, o2_tmo;
  logic [3:0]  o2_be;

  wb_obi_bridge #(
    .SOC_ADDR_WIDTH(32), .ADDR_OFFSET(32'h0), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TO_DATA)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_addr_i(wb_addr), .wb_rdata_o(wb_rdata), .wb_wdata_i(wb_wdata),
    .wb_wr_en_i(wb_we), .wb_byte_en_i(wb_be), .wb_stb_i(wb_stb),
    .wb_ack_o(wb_ack), .wb_cyc_i(wb_cyc),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
    .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
    .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
    .busy_o(busy), .timeout_o(tmo)
  );

  wb_obi_bridge #(
    .SOC_ADDR_WIDTH(32), .ADDR_OFFSET(OFF2), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TO_DATA)
  ) u_dut_off (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_addr_i(wb_addr), .wb_rdata_o(o2_rdata), .wb_wdata_i(wb_wdata),
    .wb_wr_en_i(wb_we), .wb_byte_en_i(wb_be), .wb_stb_i(wb_stb),
    .wb_ack_o(o2_ack), .wb_cyc_i(wb_cyc),
    .obi_req_o(o2_req), .obi_gnt_i(obi_gnt), .obi_addr_o(o2_addr),
    .obi_we_o(o2_we), .obi_be_o(o2_be), .obi_wdata_o(o2_wdata),
    .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
    .busy_o(o2_busy), .timeout_o(o2_tmo)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          orphan_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero();
    check_eq("z_ack",     wb_ack,   0);
    check_eq("z_rdata",   wb_rdata, 0);
    check_eq("z_req",     obi_req,  0);
    check_eq("z_addr",    obi_addr, 0);
    check_eq("z_ctl",     {obi_we, obi_be, obi_wdata}, 0);
    check_eq("z_busy",    busy,     0);
    check_eq("z_timeout", tmo,      0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wb_cyc = 1'($urandom);   // cyc without stb must not start anything
      wb_stb = 1'b0;
      obi_gnt = 1'b0; obi_rvalid = 1'b0;
      #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_req",  obi_req, 0);
      check_eq("idle_ack",  wb_ack, 0);
    end
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int g, input int r, input int lo,
                         input logic [31:0] rdata, input int abort_c, input bit noise);
    int          a_cyc, req_last;
    bit          to, cyc_now;
    logic [31:0] exp_rd, exp_off;
    // Reference: T REQ/RESP cycles are allowed; completion needs g+1 REQ
    // cycles plus r+1 RESP cycles.
    to       = (g + r + 2) > int'(T);
    a_cyc    = to ? int'(T) + 1 : g + r + 3;
    req_last = (g >= int'(T)) ? int'(T) : g + 1;
    exp_rd   = to ? TO_DATA : (we ? 32'h0 : rdata);
    exp_off  = addr + OFF2;
    if (abort_c == 0) exp_q.push_back(exp_rd);

    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    wb_addr = addr; wb_we = we; wb_be = be; wb_wdata = wdata;
    obi_gnt = 1'b0; obi_rvalid = 1'b0;
    #1;
    check_eq("accept_idle", busy, 0);

    for (int c = 1; c <= a_cyc; c++) begin
      @(posedge clk); #1;
      cyc_now = !(abort_c != 0 && c >= abort_c);
      wb_cyc = cyc_now; wb_stb = cyc_now;
      // Address phase must come from the bridge's registers, not the bus.
      wb_addr = $urandom; wb_wdata = $urandom; wb_be = 4'($urandom); wb_we = 1'($urandom);
      obi_gnt    = (g < int'(T)) && (c == g + 1);
      obi_rvalid = 1'b0;
      obi_rdata  = $urandom;
      if (noise && c <= g) obi_rvalid = 1'($urandom);
      if (g < int'(T) && c >= g + 2 && c < a_cyc) begin
        if (c == g + 2 + r) begin
          obi_rvalid = 1'b1; obi_rdata = rdata;
        end else if (orphan_pending && c == g + 2 + lo) begin
          obi_rvalid = 1'b1;
        end
      end
      #1;
      check_eq("busy",    busy,    1);
      check_eq("obi_req", obi_req, c <= req_last);
      check_eq("off_flags", {o2_req, o2_ack, o2_busy, o2_tmo},
               {c <= req_last, (c == a_cyc) && cyc_now, 1'b1, (c == a_cyc) && to});
      if (obi_req) begin
        check_eq("obi_addr", obi_addr, addr);
        check_eq("obi_ctl",  {obi_we, obi_be, obi_wdata}, {we, be, wdata});
      end
      if (o2_req) begin
        check_eq("off_addr", o2_addr, exp_off);
        check_eq("off_ctl",  {o2_we, o2_be, o2_wdata}, {we, be, wdata});
      end
      check_eq("wb_ack",  wb_ack, (c == a_cyc) && cyc_now);
      check_eq("timeout", tmo,    (c == a_cyc) && to);
      if (o2_ack) check_eq("off_rdata", o2_rdata, exp_rd);
      if (wb_ack) begin
        if (exp_q.size() > 0) check_eq("rdata", wb_rdata, exp_q.pop_front());
        else                  check_eq("ack_without_txn", wb_ack, 1'b0);
      end
    end
    if (to) orphan_pending = (g < int'(T)) ? 1'b1 : orphan_pending;
    else    orphan_pending = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
  endtask

  task automatic reset_mid_resp();
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 32'h0000_0400; wb_we = 1'b0;
    wb_be = 4'hF; wb_wdata = 32'h0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
    @(posedge clk); #1;            // REQ
    obi_gnt = 1'b1;
    #1 check_eq("rst_req", obi_req, 1);
    @(posedge clk); #1;            // RESP, pull reset for one edge
    obi_gnt = 1'b0; rst_n = 1'b0;
    #1 check_eq("rst_busy_resp", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    #1 check_outputs_zero();
    orphan_pending = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_be = '0; wb_stb = 1'b0; wb_cyc = 1'b0;
    obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero();
    rst_n = 1'b1;
    idle(2);

    // Write, zero-wait
    run_txn(32'h0010_0040, 1'b1, 4'b0011, 32'hA5A5_1234, 0, 0, 0, 32'h0, 0, 0);
    idle(1);
    // Read with stalls: gnt after 3 cycles, rvalid 2 cycles later
    run_txn(32'h0000_2000, 1'b0, 4'hF, 32'h0, 3, 2, 0, 32'hCAFE_F00D, 0, 0);
    // Back-to-back reads
    run_txn(32'h0000_3000, 1'b0, 4'hF, 32'h0, 0, 0, 0, 32'h0101_0101, 0, 0);
    run_txn(32'h0000_3004, 1'b0, 4'hF, 32'h0, 1, 0, 0, 32'h0202_0202, 0, 0);
    // Timeout in RESP, then late response discarded in the next read
    run_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0, 0, 100, 0, 32'h0, 0, 0);
    run_txn(32'h0000_4004, 1'b0, 4'hF, 32'h0, 0, 3, 1, 32'h1111_2222, 0, 0);
    // Timeout in REQ (never granted), write gets TIMEOUT_DATA
    run_txn(32'h0000_5000, 1'b1, 4'h1, 32'h5555_AAAA, int'(T), 0, 0, 32'h0, 0, 1);
    // Completion in the last allowed cycle wins over timeout
    run_txn(32'h0000_6000, 1'b0, 4'hF, 32'h0, 2, 4, 0, 32'h6666_7777, 0, 0);
    // Grant in the last allowed REQ cycle: timeout, response owed
    run_txn(32'h0000_6100, 1'b0, 4'hF, 32'h0, int'(T) - 1, 0, 0, 32'h0, 0, 0);
    run_txn(32'h0000_6104, 1'b0, 4'hF, 32'h0, 0, 2, 0, 32'h7777_8888, 0, 0);
    // Abort while in REQ
    run_txn(32'h0000_7000, 1'b0, 4'hF, 32'h0, 2, 1, 0, 32'h9999_0000, 2, 0);
    idle(1);
    // Set an orphan, then reset mid-RESP clears it
    run_txn(32'h0000_8000, 1'b0, 4'hF, 32'h0, 0, 100, 0, 32'h0, 0, 0);
    reset_mid_resp();
    idle(1);
    run_txn(32'h0000_8004, 1'b0, 4'hF, 32'h0, 0, 0, 0, 32'h3333_4444, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int g, r, lo, ab;
      g  = ($urandom_range(0, 9) == 0) ? int'(T) : int'($urandom_range(0, 4));
      r  = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(1, 6));
      lo = int'($urandom_range(0, 5)) % r;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn($urandom, 1'($urandom), 4'($urandom), $urandom, g, r, lo, $urandom,
              ab, 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_obi_bridge.md
Name: wb_obi_bridge

Overview:
Wishbone-classic responder that converts each WB access into a single OBI initiator transaction. It lets an external WB master (host/debug port) reach the core-side OBI fabric: RAM arbiter port, peripherals. One outstanding transaction at a time. A response timeout guarantees the WB master always receives an ack.

Parameters:
SOC_ADDR_WIDTH, 32, width of WB and OBI address buses
ADDR_OFFSET, 32'h0000_0000, constant added to wb_addr_i to form obi_addr_o (modulo 2^SOC_ADDR_WIDTH)
TIMEOUT_CYCLES, 255, cycles allowed in REQ+RESP before forced completion; must be >= 2
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
wb_addr_i  in  SOC_ADDR_WIDTH  WB byte address
wb_rdata_o  out  32  WB read data, valid while wb_ack_o=1
wb_wdata_i  in  32  WB write data
wb_wr_en_i  in  1  1=write, 0=read
wb_byte_en_i  in  4  byte lane enables
wb_stb_i  in  1  strobe
wb_ack_o  out  1  single-cycle acknowledge
wb_cyc_i  in  1  bus cycle
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  SOC_ADDR_WIDTH  OBI address
obi_we_o  out  1  OBI write enable
obi_be_o  out  4  OBI byte enables
obi_wdata_o  out  32  OBI write data
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  32  OBI read data
busy_o  out  1  1 whenever state != IDLE
timeout_o  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Clock/reset: one clock clk_i; reset rst_ni synchronous, active-low. While reset is asserted, all outputs are 0, state=IDLE, counter=0, orphan flag=0.
- States: IDLE, REQ, RESP, ACK.
- IDLE: if wb_cyc_i && wb_stb_i at edge k, latch addr+ADDR_OFFSET, we, be, wdata into registers; go to REQ. obi_req_o=1 from cycle k+1. All OBI address-phase outputs come from registers only and stay stable while obi_req_o=1.
- REQ: obi_req_o=1. If obi_gnt_i=1, go to RESP; obi_req_o=0 the next cycle. obi_rvalid_i is ignored in REQ.
- RESP: on obi_rvalid_i, capture obi_rdata_i for reads. Writes return 0 on wb_rdata_o. Go to ACK.
- Orphan flag: if the orphan flag is set, the first obi_rvalid_i seen in RESP clears the flag and is discarded. The bridge stays in RESP.
- ACK: wb_ack_o=1 for exactly one cycle if wb_cyc_i=1. If wb_cyc_i=0 (master aborted), no ack is issued and the captured data is dropped. Always go to IDLE next.
- wb_rdata_o holds its value outside ack; its value is don't-care there.
- Minimum latency (gnt in first REQ cycle, rvalid in first RESP cycle): stb sampled at edge k → wb_ack_o high in cycle k+3.
- Back-to-back: IDLE may accept a new stb in the cycle right after ACK.
- Abort: wb_cyc_i falling in REQ or RESP does not cancel the OBI transaction. It completes normally; only the ack is suppressed.
- Timeout counter: cleared on entry to REQ and increments each cycle in REQ/RESP. Reaching TIMEOUT_CYCLES with no completion in that cycle triggers a timeout:
  - go to ACK with wb_rdata_o=TIMEOUT_DATA (reads and writes);
  - timeout_o=1 for that one cycle;
  - in REQ, obi_req_o is withdrawn (a deliberate OBI exception);
  - in RESP, the orphan flag is set.
- Simultaneous completion and timeout: completion wins; no timeout.
- Reset mid-transaction aborts everything and clears the orphan flag. No ack is issued.

Test Plan:
- Write: addr=0x0010_0040, wdata=0xA5A5_1234, be=4'b0011, gnt and rvalid immediate → obi_addr_o=0x0010_0040 (ADDR_OFFSET=0), obi_we_o=1, obi_be_o=0011, wdata matches; wb_ack_o exactly 1 cycle at k+3.
- Read with stalls: gnt after 3 cycles, rvalid 2 cycles later with rdata=0xCAFE_F00D → obi_req_o held 4 cycles with stable address; wb_rdata_o=0xCAFE_F00D at ack; busy_o=1 throughout.
- Back-to-back: two reads, stb reasserted the cycle after ack → second obi_req_o rises 1 cycle after the first ack; no lost or duplicated acks.
- Timeout in RESP (TIMEOUT_CYCLES=8): gnt given, rvalid withheld → ack with 0xDEAD_BEEF and timeout_o pulse. Late rvalid arrives during the next read's RESP → discarded; the following rvalid (0x1111_2222) is returned.
- Abort: wb_cyc_i dropped while in REQ → OBI transaction still completes; wb_ack_o stays 0; bridge returns to IDLE.
- Reset mid-RESP: rst_ni low for 1 cycle → all outputs 0 and IDLE next cycle. A subsequent read completes normally with no orphan discard.
